lsu_seq: RTL and testbench

- Multi-cycle load/store sequencer between the decoded memory controls (read enable, write enable, load/store width codes, ALU address) and a req/ack data-memory port.
- Stalls the core while an access is in flight.
- Builds byte masks and replicated store data.
- Extracts and sign/zero-extends load data.
- Flags misaligned accesses and memory timeouts.

---
 rtl/lsu_seq_if.sv | 30 +++
 rtl/lsu_seq.sv | 184 ++++++++++++++++++
 tb/tb_lsu_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_seq_if.sv
// rtl/lsu_seq_if.sv - req/ack data-memory port between the load/store sequencer and memory
interface lsu_seq_if;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_bmask;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   modport master (
      output o_mem_req,
      output o_mem_we,
      output o_mem_addr,
      output o_mem_bmask,
      output o_mem_wdata,
      input  i_mem_ack,
      input  i_mem_rdata
   );

   modport slave (
      input  o_mem_req,
      input  o_mem_we,
      input  o_mem_addr,
      input  o_mem_bmask,
      input  o_mem_wdata,
      output i_mem_ack,
      output i_mem_rdata
   );
endinterface

// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - multi-cycle load/store sequencer with byte lanes, load extension and timeout
module lsu_seq #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rden,
   input  logic        i_mem_wren,
   input  logic [2:0]  i_ld_rewrite,
   input  logic [1:0]  i_st_rewrite,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   output logic        o_stall,
   output logic [31:0] o_ld_data,
   output logic        o_ld_vld,
   output logic        o_err,
   output logic [1:0]  o_err_code,
   lsu_seq_if.master   mem
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  err_code_nx;

   logic [CW-1:0] cnt;
   logic          we_q;
   logic          is_load_q;
   logic [2:0]    ld_code_q;
   logic [1:0]    off_q;
   logic [31:0]   addr_q;
   logic [3:0]    bmask_q;
   logic [31:0]   wdata_q;
   logic [31:0]   ld_data_q;
   logic [1:0]    err_code_q;

   logic        st_go, ld_go, start, misal;
   logic [1:0]  size;
   logic [3:0]  bmask_d;
   logic [31:0] wdata_d;
   logic [31:0] ld_ext;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Decode of the start request; a store takes priority over a load.
   always_comb begin
      st_go = i_mem_wren && (i_st_rewrite != 2'd3);
      ld_go = i_rden && (i_ld_rewrite <= 3'd4);
      start = st_go || ld_go;
      size  = 2'd2;
      if (st_go) begin
         size = i_st_rewrite;
      end else begin
         case (i_ld_rewrite)
            3'd0, 3'd3: size = 2'd0;
            3'd1, 3'd4: size = 2'd1;
            default:    size = 2'd2;
         endcase
      end
      misal = ((size == 2'd1) && i_addr[0]) ||
              ((size == 2'd2) && (i_addr[1:0] != 2'b00));
   end

   always_comb begin
      bmask_d = 4'b1111;
      wdata_d = 32'd0;
      case (size)
         2'd0: bmask_d = 4'b0001 << i_addr[1:0];
         2'd1: bmask_d = 4'b0011 << i_addr[1:0];
         default: bmask_d = 4'b1111;
      endcase
      if (st_go) begin
         case (size)
            2'd0:    wdata_d = {4{i_st_data[7:0]}};
            2'd1:    wdata_d = {2{i_st_data[15:0]}};
            default: wdata_d = i_st_data;
         endcase
      end
   end

   // Lane selection uses the offset latched at start, not the live address.
   always_comb begin
      rd_byte = 8'd0;
      case (off_q)
         2'd0: rd_byte = mem.i_mem_rdata[7:0];
         2'd1: rd_byte = mem.i_mem_rdata[15:8];
         2'd2: rd_byte = mem.i_mem_rdata[23:16];
         default: rd_byte = mem.i_mem_rdata[31:24];
      endcase
      rd_half = off_q[1] ? mem.i_mem_rdata[31:16] : mem.i_mem_rdata[15:0];
      case (ld_code_q)
         3'd0:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
         3'd3:    ld_ext = {24'd0, rd_byte};
         3'd4:    ld_ext = {16'd0, rd_half};
         default: ld_ext = mem.i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      err_code_nx = 2'b00;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (misal) begin
                  state_nx    = S_ERR;
                  err_code_nx = 2'b01;
               end else begin
                  state_nx = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem.i_mem_ack) begin
               state_nx = S_DONE;
            end else if (cnt == CNT_LAST) begin
               state_nx    = S_ERR;
               err_code_nx = 2'b10;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt        <= '0;
         we_q       <= 1'b0;
         is_load_q  <= 1'b0;
         ld_code_q  <= 3'd5;
         off_q      <= 2'd0;
         addr_q     <= 32'd0;
         bmask_q    <= 4'd0;
         wdata_q    <= 32'd0;
         ld_data_q  <= 32'd0;
         err_code_q <= 2'b00;
      end else begin
         err_code_q <= err_code_nx;
         cnt        <= (state == S_REQ) ? cnt + 1'b1 : '0;
         if ((state == S_IDLE) && start && !misal) begin
            we_q      <= st_go;
            is_load_q <= !st_go;
            ld_code_q <= st_go ? 3'd5 : i_ld_rewrite;
            off_q     <= i_addr[1:0];
            addr_q    <= {i_addr[31:2], 2'b00};
            bmask_q   <= bmask_d;
            wdata_q   <= wdata_d;
         end
         if ((state == S_REQ) && mem.i_mem_ack && is_load_q) begin
            ld_data_q <= ld_ext;
         end
      end
   end

   assign o_stall          = ((state == S_IDLE) && start) || (state == S_REQ);
   assign mem.o_mem_req    = (state == S_REQ);
   assign mem.o_mem_we     = (state == S_REQ) && we_q;
   assign mem.o_mem_addr   = addr_q;
   assign mem.o_mem_bmask  = bmask_q;
   assign mem.o_mem_wdata  = wdata_q;
   assign o_ld_data        = ld_data_q;
   assign o_ld_vld         = (state == S_DONE) && is_load_q;
   assign o_err            = (state == S_ERR);
   assign o_err_code       = err_code_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb/tb_lsu_seq.sv - directed scoreboard bench for the load/store sequencer
module tb_lsu_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        rden, wren;
   logic [2:0]  ld_rw;
   logic [1:0]  st_rw;
   logic [31:0] addr, st_data;
   logic        stall, ld_vld, err;
   logic [31:0] ld_data;
   logic [1:0]  err_code;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] sb_q[$];

   logic [31:0] snap_addr, snap_wdata;
   logic [3:0]  snap_bmask;
   logic        snap_we;
   int          stalls, reqs;

   lsu_seq_if bus ();

   lsu_seq #(.TIMEOUT(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rden       (rden),
      .i_mem_wren   (wren),
      .i_ld_rewrite (ld_rw),
      .i_st_rewrite (st_rw),
      .i_addr       (addr),
      .i_st_data    (st_data),
      .o_stall      (stall),
      .o_ld_data    (ld_data),
      .o_ld_vld     (ld_vld),
      .o_err        (err),
      .o_err_code   (err_code),
      .mem          (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rden  = 1'b0;
      wren  = 1'b0;
      ld_rw = 3'd5;
      st_rw = 2'd3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ld_vld) begin
         if (sb_q.size() == 0) chk("ld_vld_spurious", {31'd0, ld_vld}, 32'd0);
         else                  chk("ld_data_sb", ld_data, sb_q.pop_front());
      end
   endtask

   task automatic start_ld(input logic [2:0] code, input logic [31:0] a);
      idle_inputs();
      rden  = 1'b1;
      ld_rw = code;
      addr  = a;
   endtask

   task automatic start_st(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
      idle_inputs();
      wren    = 1'b1;
      st_rw   = code;
      addr    = a;
      st_data = d;
   endtask

   // Runs from the start cycle until stall drops; ack_n is the REQ cycle that acks (0 = never).
   task automatic run_access(input int ack_n, input logic [31:0] rd);
      bit done = 0;
      stalls = 0;
      reqs   = 0;
      #1;
      if (stall) stalls++;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         idle_inputs();
         bus.i_mem_ack = 1'b0;
         #1;
         if (stall) stalls++;
         if (bus.o_mem_req) begin
            reqs++;
            if (reqs == 1) begin
               snap_addr  = bus.o_mem_addr;
               snap_bmask = bus.o_mem_bmask;
               snap_wdata = bus.o_mem_wdata;
               snap_we    = bus.o_mem_we;
            end
            if (reqs == ack_n) begin
               bus.i_mem_ack   = 1'b1;
               bus.i_mem_rdata = rd;
            end
         end
         if (!stall) done = 1;
      end
      chk("access_bound", {31'd0, done}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      addr = 32'd0;
      st_data = 32'd0;
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_req",   {31'd0, bus.o_mem_req}, 32'd0);
      chk("rst_we",    {31'd0, bus.o_mem_we}, 32'd0);
      chk("rst_addr",  bus.o_mem_addr, 32'd0);
      chk("rst_bmask", {28'd0, bus.o_mem_bmask}, 32'd0);
      chk("rst_wdata", bus.o_mem_wdata, 32'd0);
      chk("rst_ld",    ld_data, 32'd0);
      chk("rst_flags", {28'd0, stall, ld_vld, err, 1'b0}, 32'd0);
      chk("rst_code",  {30'd0, err_code}, 32'd0);

      // LW, ack on third REQ cycle
      tick();
      start_ld(3'd2, 32'h0000_0100);
      sb_q.push_back(32'hDEAD_BEEF);
      run_access(3, 32'hDEAD_BEEF);
      chk("lw_addr",   snap_addr, 32'h0000_0100);
      chk("lw_bmask",  {28'd0, snap_bmask}, 32'h0000_000F);
      chk("lw_we",     {31'd0, snap_we}, 32'd0);
      chk("lw_stalls", stalls, 32'd4);
      chk("lw_vld",    {31'd0, ld_vld}, 32'd1);
      chk("lw_data",   ld_data, 32'hDEAD_BEEF);

      // LB and LBU at byte 3
      tick();
      start_ld(3'd0, 32'h0000_0203);
      sb_q.push_back(32'hFFFF_FF80);
      run_access(1, 32'h80FF_1234);
      chk("lb_addr",   snap_addr, 32'h0000_0200);
      chk("lb_bmask",  {28'd0, snap_bmask}, 32'h0000_0008);
      chk("lb_stalls", stalls, 32'd2);
      chk("lb_data",   ld_data, 32'hFFFF_FF80);
      tick();
      start_ld(3'd3, 32'h0000_0203);
      sb_q.push_back(32'h0000_0080);
      run_access(1, 32'h80FF_1234);
      chk("lbu_data",  ld_data, 32'h0000_0080);

      // LH and LHU on upper halfword
      tick();
      start_ld(3'd1, 32'h0000_0202);
      sb_q.push_back(32'hFFFF_80FF);
      run_access(1, 32'h80FF_1234);
      chk("lh_bmask",  {28'd0, snap_bmask}, 32'h0000_000C);
      tick();
      start_ld(3'd4, 32'h0000_0206);
      sb_q.push_back(32'h0000_80FF);
      run_access(2, 32'h80FF_1234);
      chk("lhu_stalls", stalls, 32'd3);

      // SH upper half
      tick();
      start_st(2'd1, 32'h0000_0102, 32'h1234_ABCD);
      run_access(1, 32'h0);
      chk("sh_bmask",  {28'd0, snap_bmask}, 32'h0000_000C);
      chk("sh_wdata",  snap_wdata, 32'hABCD_ABCD);
      chk("sh_we",     {31'd0, snap_we}, 32'd1);
      chk("sh_stalls", stalls, 32'd2);
      chk("sh_novld",  {31'd0, ld_vld}, 32'd0);
      chk("sh_ldhold", ld_data, 32'h0000_80FF);

      // Misaligned LW
      tick();
      start_ld(3'd2, 32'h0000_0102);
      #1;
      chk("mis_stall0", {31'd0, stall}, 32'd1);
      run_access(0, 32'h0);
      chk("mis_reqs",  reqs, 32'd0);
      chk("mis_err",   {31'd0, err}, 32'd1);
      chk("mis_code",  {30'd0, err_code}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("mis_clear", {29'd0, err, err_code}, 32'd0);

      // SW timeout, then a late ack is ignored
      start_st(2'd2, 32'h0000_0300, 32'h5555_AAAA);
      run_access(0, 32'h0);
      chk("to_reqs",   reqs, 32'd16);
      chk("to_wdata",  snap_wdata, 32'h5555_AAAA);
      chk("to_err",    {31'd0, err}, 32'd1);
      chk("to_code",   {30'd0, err_code}, 32'd2);
      chk("to_reqdrop", {31'd0, bus.o_mem_req}, 32'd0);
      tick();
      bus.i_mem_ack = 1'b1;
      tick();
      bus.i_mem_ack = 1'b0;
      chk("to_idle",   {28'd0, stall, bus.o_mem_req, err, ld_vld}, 32'd0);
      chk("to_code0",  {30'd0, err_code}, 32'd0);

      // Reset during second REQ cycle of an LH
      start_ld(3'd1, 32'h0000_0402);
      tick();
      idle_inputs();
      #1;
      chk("rq_req1", {31'd0, bus.o_mem_req}, 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rq_outs",  {27'd0, stall, bus.o_mem_req, bus.o_mem_we, err, ld_vld}, 32'd0);
      chk("rq_addr",  bus.o_mem_addr, 32'd0);
      chk("rq_bmask", {28'd0, bus.o_mem_bmask}, 32'd0);
      chk("rq_ld",    ld_data, 32'd0);
      bus.i_mem_ack = 1'b1;
      bus.i_mem_rdata = 32'h1111_2222;
      tick();
      bus.i_mem_ack = 1'b0;
      tick();
      chk("rq_novld", {31'd0, ld_vld}, 32'd0);

      // SB after reset completes normally
      start_st(2'd0, 32'h0000_0101, 32'h0000_00A5);
      run_access(1, 32'h0);
      chk("sb_bmask",  {28'd0, snap_bmask}, 32'h0000_0002);
      chk("sb_wdata",  snap_wdata, 32'hA5A5_A5A5);
      chk("sb_addr",   snap_addr, 32'h0000_0100);
      chk("sb_stalls", stalls, 32'd2);
      tick();
      chk("sb_empty",  sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
